contadores_ram: RTL and testbench

CONTADORES_RAM -- requirements
Module: contadores_ram

---
 rtl/contadores_pkg.sv | 7 +
 rtl/contador_cell.sv | 38 +++
 rtl/contadores_ram.sv | 47 ++++
 tb/tb_contadores_ram.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/contadores_pkg.sv
// Shared defaults for the counter-array block.
package contadores_pkg;

    localparam int unsigned ADDR_W_DEF = 6;
    localparam int unsigned CNT_W_DEF  = 4;

endpackage : contadores_pkg

// File: rtl/contador_cell.sv
// Single wrapping counter: clear beats increment, asynchronous active-low reset.
module contador_cell
    import contadores_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             gen_reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // Next count: clear has priority, otherwise increment modulo 2**CNT_W.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge gen_reset) begin
        if (!gen_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule : contador_cell

// File: rtl/contadores_ram.sv
// Array of 2**ADDR_W independent counters with one shared address for
// update and for a zero-latency combinational read.
module contadores_ram
    import contadores_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              gen_reset,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] adress,
    input  logic              count_read,
    input  logic              count_reset,
    output logic [CNT_W-1:0]  count_out
);

    localparam int unsigned NUM_CNT = 2 ** ADDR_W;

    logic [CNT_W-1:0] cnt_arr [NUM_CNT];

    // One counter per address; the decoder steers inc/clr to the selected cell only.
    for (genvar i = 0; i < NUM_CNT; i++) begin : g_cell
        logic sel;

        assign sel = (adress == ADDR_W'(i));

        contador_cell #(
            .CNT_W (CNT_W)
        ) u_cell (
            .clk       (clk),
            .gen_reset (gen_reset),
            .inc       (sel & write_enable),
            .clr       (sel & count_reset),
            .cnt       (cnt_arr[i])
        );
    end

    // Read mux: addressed counter when enabled, forced to zero while in reset.
    always_comb begin
        count_out = '0;
        if (count_read && gen_reset) begin
            count_out = cnt_arr[adress];
        end
    end

endmodule : contadores_ram

// File: tb/tb_contadores_ram.sv
// Scoreboard bench: stimulus pushes expected count_out values, a monitor
// pops and compares them at the falling edge, away from the active edge.
module tb_contadores_ram;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned CNT_W  = 4;

    typedef struct {
        string            name;
        logic [CNT_W-1:0] exp;
    } exp_t;

    logic              clk;
    logic              gen_reset;
    logic              write_enable;
    logic [ADDR_W-1:0] adress;
    logic              count_read;
    logic              count_reset;
    logic [CNT_W-1:0]  count_out;

    exp_t exp_q[$];
    int   n_cmp;
    int   n_bad;

    contadores_ram #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk          (clk),
        .gen_reset    (gen_reset),
        .write_enable (write_enable),
        .adress       (adress),
        .count_read   (count_read),
        .count_reset  (count_reset),
        .count_out    (count_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: each falling edge consumes at most one pending expectation.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (count_out !== e.exp) begin
                n_bad++;
                $display("FAIL %s: count_out=%0d required=%0d", e.name, count_out, e.exp);
            end
        end
    end

    // Queue an expectation and let the monitor compare it at the next falling edge.
    task automatic chk(input string name, input logic [CNT_W-1:0] exp);
        exp_t e;
        e.name = name;
        e.exp  = exp;
        exp_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Read a given address with count_read=1.
    task automatic rd(input string name, input int a, input logic [CNT_W-1:0] exp);
        adress     = ADDR_W'(a);
        count_read = 1'b1;
        chk(name, exp);
    endtask

    // One write_enable pulse at address a.
    task automatic inc1(input int a);
        adress       = ADDR_W'(a);
        write_enable = 1'b1;
        step();
        write_enable = 1'b0;
    endtask

    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        gen_reset    = 1'b0;
        write_enable = 1'b0;
        adress       = '0;
        count_read   = 1'b1;
        count_reset  = 1'b0;

        // In reset: output zero and increments ignored.
        chk("reset_out", 4'd0);
        write_enable = 1'b1;
        step();
        chk("reset_ignores_we", 4'd0);
        write_enable = 1'b0;
        gen_reset    = 1'b1;
        step();

        // Every address reads zero after reset.
        for (int a = 0; a < 64; a++) begin
            rd($sformatf("zero_addr%0d", a), a, 4'd0);
        end

        // Single increments at 1, 2, 4, 8.
        inc1(1);
        inc1(2);
        inc1(4);
        inc1(8);
        rd("one_addr1", 1, 4'd1);
        rd("one_addr2", 2, 4'd1);
        rd("one_addr4", 4, 4'd1);
        rd("one_addr8", 8, 4'd1);
        rd("untouched_addr3", 3, 4'd0);

        // Idle cycle leaves everything alone.
        adress = ADDR_W'(1);
        step();
        rd("idle_hold_addr1", 1, 4'd1);

        // Address 2 to three, then clear with write_enable also high.
        inc1(2);
        rd("addr2_two", 2, 4'd2);
        inc1(2);
        rd("addr2_three", 2, 4'd3);
        adress       = ADDR_W'(2);
        write_enable = 1'b1;
        count_reset  = 1'b1;
        step();
        write_enable = 1'b0;
        count_reset  = 1'b0;
        rd("clr_priority_addr2", 2, 4'd0);
        rd("neighbour_addr1", 1, 4'd1);
        rd("neighbour_addr4", 4, 4'd1);
        rd("neighbour_addr8", 8, 4'd1);

        // Sixteen back-to-back increments at address 5 wrap to zero.
        adress       = ADDR_W'(5);
        write_enable = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            chk($sformatf("wrap_addr5_k%0d", k), CNT_W'(k));
        end
        write_enable = 1'b0;

        // Read disable forces zero; high addresses never touched.
        adress     = ADDR_W'(1);
        count_read = 1'b0;
        chk("read_disabled_addr1", 4'd0);
        rd("untouched_addr62", 62, 4'd0);
        rd("untouched_addr63", 63, 4'd0);

        // Load address 7 to two and the top address to one.
        inc1(7);
        inc1(7);
        inc1(63);
        rd("loaded_addr7", 7, 4'd2);
        rd("loaded_addr63", 63, 4'd1);

        // Reset pulse between edges clears everything at once.
        adress = ADDR_W'(7);
        step();
        gen_reset = 1'b0;
        chk("async_reset_addr7", 4'd0);
        gen_reset = 1'b1;
        rd("after_reset_addr1", 1, 4'd0);
        rd("after_reset_addr63", 63, 4'd0);
        rd("after_reset_addr8", 8, 4'd0);

        // Counting resumes after release.
        inc1(1);
        rd("post_reset_inc_addr1", 1, 4'd1);

        // Any expectation left unconsumed is a failure.
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain: pending=%0d required=0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: time=%0t required=finish", $time);
        $fatal(1);
    end

endmodule : tb_contadores_ram
